fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the fifo1 write port among NREQ producers in the wclk domain.
//   - Grants one requester at a time for a burst: up to MAX_BURST beats, or ended early by req_last.
//   - Drives wdata/winc into the FIFO and never writes while wfull is high.
//   - Sits directly in front of fifo1's write side. The read side is untouched.
// PARAMETERS
//   DSIZE      8   data width; matches fifo1 DSIZE
//   NREQ       4   number of requesters (2..8)
//   MAX_BURST  16  max beats per grant (1..256); burst counter is clog2(MAX_BURST+1) bits
// PORTS
//   wclk          in   1           write-domain clock; all logic on rising edge
//   wrst_n        in   1           asynchronous reset, active low
//   req_valid     in   NREQ        requester i has a beat on req_data slice i
//   req_data      in   NREQ*DSIZE  packed data; slice i = [i*DSIZE +: DSIZE]
//   req_last      in   NREQ        beat from requester i ends its burst
//   req_ready     out  NREQ        beat from requester i accepted this cycle when valid&ready
//   wdata         out  DSIZE       to fifo1 wdata
//   winc          out  1           to fifo1 winc
//   wfull         in   1           from fifo1 wfull (registered in wclk domain)
//   gnt           out  NREQ        one-hot current grant; all zero when idle
//   burst_active  out  1           high in BURST state
// BEHAVIOUR
//   Reset (wrst_n=0, async)
//     - state=IDLE, gnt=0, burst counter=0, rr pointer=NREQ-1 (so requester 0 has first priority).
//     - Outputs during reset: req_ready=0, winc=0, burst_active=0, wdata=0.
//   FSM IDLE
//     - If any req_valid: pick the first set bit searching from (ptr+1) mod NREQ upward with wrap.
//     - Register that pick into gnt and go to BURST.
//     - This costs one arbitration bubble cycle; nothing is written in IDLE.
//   FSM BURST (granted index g)
//     - req_ready[g] = !wfull. All other req_ready bits are 0.
//     - winc = req_valid[g] & !wfull.
//     - wdata = req_data slice g (combinational mux, zero latency).
//     - Each accepted beat increments the burst counter.
//     - Exit to IDLE when either holds:
//       (a) accepted beat has req_last[g]=1;
//       (b) accepted beat is beat number MAX_BURST.
//     - On exit: ptr<=g, counter<=0, gnt<=0.
//     - If req_valid[g] drops mid-burst, the grant is held; there is no timeout or preemption.
//   Output values outside writes
//     - wdata=0 whenever winc=0. Bench may check this; it keeps the FIFO input quiet.
//   Boundaries
//     - wfull high: winc=0, ready=0, counter holds, state holds.
//       First write resumes the cycle after wfull falls, i.e. same cycle wfull is sampled low.
//     - wfull and last on the same cycle: beat is not accepted, so no exit.
//     - MAX_BURST=1: exactly one beat per grant, then IDLE.
//     - Wrap: ptr=NREQ-1 searches 0,1,..; a lone requester is re-granted after each bubble.
//     - Reset mid-burst: immediate return to IDLE; the partial burst is abandoned.
//   Throughput and invariants
//     - Throughput is 1 beat/cycle within a burst, plus 1 idle cycle between grants.
//     - winc is never 1 in a cycle where wfull=1 (overflow-safe).
// TESTING
//   1) Reset then only req0 streams 20 beats (last on beat 20), MAX_BURST=16.
//      -> gnt=0001 bubble; beats 1-16 written; 1 bubble; beats 17-20 written; fifo reads 1..20 in order.
//   2) All 4 requesters valid continuously, last on every 3rd beat.
//      -> grant order 0,1,2,3,0...; 3 beats each; fifo data groups by requester.
//   3) Hold wfull=1 for 10 cycles mid-burst.
//      -> winc=0 and req_ready=0 throughout; counter frozen; burst resumes with no lost or duplicated beat.
//   4) Req2 drops valid for 5 cycles mid-burst while req1 is valid.
//      -> gnt stays 0100; no write to fifo; req1 not served until req2 sends last.
//   5) Assert wrst_n=0 for 1 cycle during beat 7 of req3's burst.
//      -> gnt=0, winc=0 immediately; after release next grant goes to req0 first.
//   6) Integrated with fifo1 (wperiod 12.5, rperiod 15.87), 120 beats from 2 requesters.
//      -> never winc&wfull; all 120 bytes read exactly once.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo1 write port among NREQ producers.
// Grants one requester per burst; bursts end on req_last or after MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                   wclk,
  input  logic                   wrst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DSIZE-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [DSIZE-1:0]       wdata,
  output logic                   winc,
  input  logic                   wfull,
  output logic [NREQ-1:0]        gnt,
  output logic                   burst_active
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            accept;
  logic            last_beat;

  // Search from ptr+1 upward with wrap; first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((int'(ptr) + k) % int'(NREQ));
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign burst_active = (state == BURST);
  assign accept       = burst_active && req_valid[gidx] && !wfull;
  assign last_beat    = req_last[gidx] || (cnt == CW'(MAX_BURST - 1));

  // Write port is a zero-latency mux off the granted slice, held at zero otherwise.
  assign winc      = accept;
  assign req_ready = (burst_active && !wfull) ? gnt : '0;
  assign wdata     = accept ? req_data[gidx*DSIZE +: DSIZE] : '0;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= IW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt   <= NREQ'(1) << pick_idx;
            gidx  <= pick_idx;
            state <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (last_beat) begin
              state <= IDLE;
              gnt   <= '0;
              cnt   <= '0;
              ptr   <= gidx;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for single-cycle behaviour,
// plus streaming, wfull-stall and mid-burst reset sequences.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  wdata;
  logic        winc;
  logic        wfull;
  logic [3:0]  gnt;
  logic        burst_active;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wdata(wdata), .winc(winc), .wfull(wfull),
    .gnt(gnt), .burst_active(burst_active)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  e_gnt;
    logic [3:0]  e_ready;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic        e_ba;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] er,
                         input logic ew, input logic [7:0] ed, input logic eb);
    chk({tag, " gnt"}, 32'(gnt), 32'(eg));
    chk({tag, " ready"}, 32'(req_ready), 32'(er));
    chk({tag, " winc"}, 32'(winc), 32'(ew));
    chk({tag, " wdata"}, 32'(wdata), 32'(ed));
    chk({tag, " burst_active"}, 32'(burst_active), 32'(eb));
  endtask

  // Lone requester idx streams nbeats (last on the final one); wfull held for
  // full_len cycles starting at cycle full_from. Small model tracks expected grant.
  task automatic run_stream(input string tag, input int idx, input int nbeats,
                            input int full_from, input int full_len);
    int  beat = 0;
    int  cnt = 0;
    bit  in_burst = 0;
    bit  wf;
    bit  ew;
    logic [3:0] onehot;
    onehot = 4'(1) << idx;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (beat == nbeats && !in_burst) break;
      @(negedge wclk);
      wf        = (cyc >= full_from) && (cyc < full_from + full_len);
      req_valid = onehot;
      req_data  = 32'(8'(beat + 1)) << (idx * 8);
      req_last  = (beat + 1 == nbeats) ? onehot : 4'b0000;
      wfull     = wf;
      #1;
      ew = in_burst && !wf;
      chk_all($sformatf("%s c%0d", tag, cyc), in_burst ? onehot : 4'b0000,
              ew ? onehot : 4'b0000, ew, ew ? 8'(beat + 1) : 8'h00, in_burst);
      if (!in_burst) begin
        in_burst = 1;
      end else if (ew) begin
        beat++;
        cnt++;
        if (beat == nbeats || cnt == 16) begin
          in_burst = 0;
          cnt = 0;
        end
      end
      if (cyc == 199) chk({tag, " timeout"}, 32'(beat), 32'(nbeats));
    end
    @(negedge wclk);
    req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    #1;
    chk_all({tag, " end"}, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{4'b0110, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{4'b0110, 4'b0000, 1'b0, 32'h0000_1100, 4'b0010, 4'b0010, 1'b1, 8'h11, 1'b1};
    vecs[3]  = '{4'b0110, 4'b0010, 1'b1, 32'h0000_EE00, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{4'b0100, 4'b0000, 1'b0, 32'h0000_EE00, 4'b0010, 4'b0010, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{4'b0110, 4'b0010, 1'b0, 32'h0000_2200, 4'b0010, 4'b0010, 1'b1, 8'h22, 1'b1};
    vecs[6]  = '{4'b0110, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{4'b0110, 4'b0100, 1'b0, 32'h0033_0000, 4'b0100, 4'b0100, 1'b1, 8'h33, 1'b1};
    vecs[8]  = '{4'b0011, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0001, 1'b0, 32'h0000_0044, 4'b0001, 4'b0001, 1'b1, 8'h44, 1'b1};
    vecs[10] = '{4'b1000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{4'b1000, 4'b1000, 1'b0, 32'h5500_0000, 4'b1000, 4'b1000, 1'b1, 8'h55, 1'b1};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

    wrst_n = 1'b0; req_valid = 4'b1111; req_last = '0; req_data = 32'hFFFF_FFFF; wfull = 1'b0;
    repeat (2) @(negedge wclk);
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1; req_valid = '0; req_data = '0;

    foreach (vecs[i]) begin
      @(negedge wclk);
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      wfull     = vecs[i].full;
      req_data  = vecs[i].data;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_ready,
              vecs[i].e_winc, vecs[i].e_wdata, vecs[i].e_ba);
    end

    run_stream("burst16", 0, 20, 1000, 0);
    run_stream("wfull", 1, 20, 5, 10);

    // Mid-burst reset during req3 beat 7; next grant must restart at req0.
    for (int c = 0; c < 7; c++) begin
      @(negedge wclk);
      req_valid = 4'b1000; req_last = '0; req_data = 32'(8'(8'h70 + c)) << 24;
      #1;
      chk($sformatf("rstseq winc c%0d", c), 32'(winc), (c == 0) ? 32'd0 : 32'd1);
    end
    @(negedge wclk);
    wrst_n = 1'b0;
    #1;
    chk_all("midrst", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1; req_valid = 4'b1001; req_data = 32'h7700_0099; req_last = 4'b1001;
    #1;
    chk_all("postrst idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
    @(negedge wclk);
    #1;
    chk_all("postrst req0", 4'b0001, 4'b0001, 1'b1, 8'h99, 1'b1);
    @(negedge wclk);
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk_all("final idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
